// File: rtl/sa_en_sequencer_pkg.sv
// sa_pkg: shared types and helpers for the systolic-array enable sequencer.
//   state_t    : sequencer FSM states
//   MODE_*     : run mode encodings (latched at start)
//   sa_clog2() : ceil(log2(v)); used to check the step counter is wide enough
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_TABLE = 1'b0;
    localparam logic MODE_WAVE  = 1'b1;

    function automatic int sa_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sa_en_table.sv
// sa_en_table: N_STEPS x N_ROWS pattern register file.
//   clk, rst : clock, async active-high reset (clears every entry)
//   we       : write strobe; caller has already qualified state and range
//   waddr    : entry written on the next rising edge
//   wdata    : entry value
//   raddr    : combinational read index
//   rdata    : entry at raddr; zero for indices beyond the table
module sa_en_table #(
    parameter int N_ROWS  = 3,
    parameter int N_STEPS = 9,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [CNT_W-1:0]  waddr,
    input  logic [N_ROWS-1:0] wdata,
    input  logic [CNT_W-1:0]  raddr,
    output logic [N_ROWS-1:0] rdata
);

    logic [N_STEPS-1:0][N_ROWS-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else begin
            for (int j = 0; j < N_STEPS; j++) begin
                if (we && (waddr == CNT_W'(j))) mem[j] <= wdata;
            end
        end
    end

    // Compare-and-select read: indices outside the table can never alias
    // onto a real entry, they simply read as zero.
    always_comb begin
        rdata = '0;
        for (int j = 0; j < N_STEPS; j++) begin
            if (raddr == CNT_W'(j)) rdata = mem[j];
        end
    end

endmodule

// File: rtl/sa_en_sequencer.sv
// sa_en_sequencer: per-row PE enable sequencer for the systolic array.
// Runs up to N_STEPS steps (TABLE mode) or len steps (WAVE mode) after a
// start request, producing one row-enable vector per step.
//   clk, rst  : clock, async active-high reset (aborts a run, no done)
//   start     : run request, only looked at in IDLE
//   stall     : freezes the step counter and masks en
//   mode      : MODE_TABLE / MODE_WAVE, latched at start
//   len       : run length in steps, latched at start
//   cfg_we    : pattern table write strobe (IDLE only, addr < N_STEPS)
//   cfg_addr  : pattern table index
//   cfg_data  : pattern table entry
//   en        : row enables for the current step
//   cnt       : current step index
//   busy      : high while running
//   done      : one-cycle pulse after the last step
module sa_en_sequencer
    import sa_pkg::*;
#(
    parameter int N_ROWS  = 3,
    parameter int N_STEPS = 9,
    parameter int CNT_W   = 4,
    parameter int WAVE_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              mode,
    input  logic [CNT_W-1:0]  len,
    input  logic              cfg_we,
    input  logic [CNT_W-1:0]  cfg_addr,
    input  logic [N_ROWS-1:0] cfg_data,
    output logic [N_ROWS-1:0] en,
    output logic [CNT_W-1:0]  cnt,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MIN = sa_clog2(N_STEPS + 1);
    localparam logic [CNT_W-1:0] NSTEPS_C = CNT_W'(N_STEPS);

    // The counter must be able to hold N_STEPS itself (len clamp value).
    if (CNT_W < CNT_MIN) begin : g_cnt_w_check
        $error("sa_en_sequencer: CNT_W too small for N_STEPS");
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  len_q;
    logic              mode_q;
    logic              busy_q;
    logic              done_q;

    logic [CNT_W-1:0]  len_eff;
    logic              cfg_ok;
    logic [N_ROWS-1:0] tab_en;
    logic [N_ROWS-1:0] wave_en;
    logic [N_ROWS-1:0] en_raw;
    logic [CNT_W:0]    cnt_x;

    // Table runs can never go past the last entry; wave runs use len as is.
    assign len_eff = ((mode == MODE_TABLE) && (len > NSTEPS_C)) ? NSTEPS_C : len;

    assign cfg_ok  = cfg_we && (state == ST_IDLE) && (cfg_addr < NSTEPS_C);

    sa_en_table #(
        .N_ROWS  (N_ROWS),
        .N_STEPS (N_STEPS),
        .CNT_W   (CNT_W)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_ok),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (cnt_q),
        .rdata (tab_en)
    );

    // Wavefront: row i is active for steps [i, i+WAVE_W). One extra bit
    // keeps i+WAVE_W from wrapping for rows near the top of the counter.
    assign cnt_x = {1'b0, cnt_q};

    for (genvar i = 0; i < N_ROWS; i++) begin : g_wave
        localparam logic [CNT_W:0] HI = (CNT_W+1)'(i + WAVE_W);
        if (i == 0) begin : g_row0
            assign wave_en[i] = (cnt_x < HI);
        end else begin : g_rown
            localparam logic [CNT_W:0] LO = (CNT_W+1)'(i);
            assign wave_en[i] = (cnt_x >= LO) && (cnt_x < HI);
        end
    end

    assign en_raw = (mode_q == MODE_WAVE) ? wave_en : tab_en;

    // Only combinational path from an input to an output: stall masking.
    assign en   = (busy_q && !stall) ? en_raw : '0;
    assign cnt  = cnt_q;
    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt_q  <= '0;
            len_q  <= '0;
            mode_q <= MODE_TABLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q <= mode;
                        len_q  <= len_eff;
                        if (len_eff == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        // Last step: cnt stays put through the DONE cycle.
                        if (cnt_q == len_q - CNT_W'(1)) begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    cnt_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_en_sequencer.sv
// Bench for sa_en_sequencer: two instances (WAVE_W=1 and WAVE_W=2) share
// all inputs; a run-level model is compared on every falling edge, and
// directed sequences pin literal expectations.
module tb_sa_en_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stall, mode, cfg_we;
    logic [3:0] len, cfg_addr;
    logic [2:0] cfg_data;

    logic [2:0] en1, en2;
    logic [3:0] cnt1, cnt2;
    logic       busy1, busy2, done1, done2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sa_en_sequencer #(.N_ROWS(3), .N_STEPS(9), .CNT_W(4), .WAVE_W(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .mode(mode),
        .len(len), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .en(en1), .cnt(cnt1), .busy(busy1), .done(done1)
    );

    sa_en_sequencer #(.N_ROWS(3), .N_STEPS(9), .CNT_W(4), .WAVE_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .mode(mode),
        .len(len), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .en(en2), .cnt(cnt2), .busy(busy2), .done(done2)
    );

    // ---------------- run-level model ----------------
    // m_ph: 0 = idle, 1 = running, 2 = done pulse
    int         m_ph   = 0;
    int         m_step = 0;
    int         m_len  = 0;
    int         m_mode = 0;
    logic [2:0] m_tab [9];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph   <= 0;
            m_step <= 0;
            m_len  <= 0;
            m_mode <= 0;
            for (int j = 0; j < 9; j++) m_tab[j] <= 3'b000;
        end else if (m_ph == 0) begin
            m_step <= 0;
            if (cfg_we && cfg_addr < 9) m_tab[cfg_addr] <= cfg_data;
            if (start) begin
                m_mode <= int'(mode);
                m_len  <= eff_len(mode, len);
                m_ph   <= (eff_len(mode, len) == 0) ? 2 : 1;
            end
        end else if (m_ph == 1) begin
            if (!stall) begin
                if (m_step + 1 >= m_len) m_ph <= 2;
                else m_step <= m_step + 1;
            end
        end else begin
            m_ph   <= 0;
            m_step <= 0;
        end
    end

    function automatic int eff_len(input logic md, input logic [3:0] l);
        if (md == 1'b0 && l > 9) return 9;
        return int'(l);
    endfunction

    function automatic logic [2:0] exp_en(input int w);
        logic [2:0] r;
        r = 3'b000;
        if (m_ph == 1 && !stall) begin
            if (m_mode == 0) r = m_tab[m_step];
            else for (int i = 0; i < 3; i++) r[i] = (m_step >= i) && (m_step < i + w);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got en/cnt/busy/done=%b want %b", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_w1", {en1, cnt1, busy1, done1},
            {exp_en(1), 4'(m_step), m_ph == 1, m_ph == 2});
        chk("model_w2", {en2, cnt2, busy2, done2},
            {exp_en(2), 4'(m_step), m_ph == 1, m_ph == 2});
    end

    // ---------------- directed sequences ----------------
    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [2:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        cyc();
        cfg_we = 1'b0;
    endtask

    logic [2:0] w1 [5];
    logic [2:0] w2 [5];

    initial begin
        int n;
        bit got;
        w1 = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
        w2 = '{3'b001, 3'b011, 3'b110, 3'b100, 3'b000};
        rst = 1'b1; start = 1'b0; stall = 1'b0; mode = 1'b0; len = 4'd0;
        cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 3'b000;
        cyc(); cyc();
        rst = 1'b0; #1;
        lit("rst_en", en1, 0); lit("rst_cnt", cnt1, 0);
        lit("rst_busy", busy1, 0); lit("rst_done", done1, 0);

        // table load; address 9 is out of range and must not land anywhere
        wr(4'd0, 3'b111); wr(4'd1, 3'b101); wr(4'd2, 3'b010); wr(4'd9, 3'b000);

        // table run
        mode = 1'b0; len = 4'd3; start = 1'b1; cyc(); start = 1'b0; #1;
        lit("tab_en0", en1, 3'b111); lit("tab_cnt0", cnt1, 0); lit("tab_busy0", busy1, 1);
        cyc(); #1; lit("tab_en1", en1, 3'b101); lit("tab_cnt1", cnt1, 1);
        cyc(); #1; lit("tab_en2", en1, 3'b010); lit("tab_cnt2", cnt1, 2);
        cyc(); #1; lit("tab_done", done1, 1); lit("tab_done_en", en1, 0); lit("tab_done_busy", busy1, 0);
        cyc(); #1; lit("tab_idle_done", done1, 0);

        // wave run, both window widths at once
        mode = 1'b1; len = 4'd5; start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            lit($sformatf("wave1_en%0d", k), en1, w1[k]);
            lit($sformatf("wave2_en%0d", k), en2, w2[k]);
            cyc();
        end
        #1; lit("wave_done", done1, 1);
        cyc();

        // stall two cycles on step 1
        mode = 1'b0; len = 4'd3; start = 1'b1; cyc(); start = 1'b0; #1;
        lit("stl_en0", en1, 3'b111);
        cyc(); stall = 1'b1; #1; lit("stl_en1", en1, 0); lit("stl_cnt1", cnt1, 1);
        cyc(); #1; lit("stl_en2", en1, 0); lit("stl_cnt2", cnt1, 1);
        cyc(); stall = 1'b0; #1; lit("stl_en3", en1, 3'b101); lit("stl_cnt3", cnt1, 1);
        cyc(); #1; lit("stl_en4", en1, 3'b010);
        cyc(); #1; lit("stl_done", done1, 1);
        cyc();

        // len = 0: straight to the done pulse
        len = 4'd0; start = 1'b1; cyc(); start = 1'b0; #1;
        lit("len0_done", done1, 1); lit("len0_en", en1, 0); lit("len0_busy", busy1, 0);
        cyc(); #1; lit("len0_idle", done1, 0);

        // len = 15 in table mode clamps to 9 steps
        wr(4'd3, 3'b100); wr(4'd4, 3'b011); wr(4'd5, 3'b110);
        wr(4'd6, 3'b001); wr(4'd7, 3'b010); wr(4'd8, 3'b111);
        mode = 1'b0; len = 4'd15; start = 1'b1; cyc(); start = 1'b0;
        n = 0; got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            #1;
            if (busy1) n++;
            if (done1) got = 1'b1;
            else cyc();
        end
        lit("len15_steps", n, 9); lit("len15_done_seen", got, 1);
        cyc();

        // start during RUN and DONE ignored; cfg write during RUN dropped
        len = 4'd3; start = 1'b1; cyc(); start = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 3'b000;
        cyc(); cfg_we = 1'b0; start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); start = 1'b1; #1; lit("abuse_done", done1, 1);
        cyc(); start = 1'b0; #1; lit("abuse_idle", busy1, 0);
        cyc(); #1; lit("abuse_norun", busy1, 0); lit("abuse_nodone", done1, 0);
        len = 4'd1; start = 1'b1; cyc(); start = 1'b0; #1;
        lit("abuse_tab0_kept", en1, 3'b111);
        cyc(); cyc();

        // reset at step 2
        len = 4'd3; start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); #1; lit("mid_cnt_pre", cnt1, 2);
        rst = 1'b1; #1;
        lit("mid_en", en1, 0); lit("mid_busy", busy1, 0);
        lit("mid_cnt", cnt1, 0); lit("mid_done", done1, 0);
        cyc(); rst = 1'b0;
        cyc(); #1; lit("mid_nodone", done1, 0); lit("mid_idle", busy1, 0);

        // table was cleared by reset
        mode = 1'b0; len = 4'd3; start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            lit($sformatf("clr_en%0d", k), en1, 0);
            lit($sformatf("clr_busy%0d", k), busy1, 1);
            cyc();
        end
        #1; lit("clr_done", done1, 1);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
